// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port, 4-VC wormhole router.
// Contents: flit-type codes, port indices, common widths, lock FSM state type and a
// helper that advances a port index with wrap-around.
package noc_pkg;

  localparam int unsigned VC_W   = 2;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned FLIT_W = 128;

  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam logic [1:0] FLIT_HT   = 2'b11;

  localparam logic [PORT_W-1:0] PORT_E = 3'd0;
  localparam logic [PORT_W-1:0] PORT_W_IDX = 3'd1;
  localparam logic [PORT_W-1:0] PORT_N = 3'd2;
  localparam logic [PORT_W-1:0] PORT_S = 3'd3;
  localparam logic [PORT_W-1:0] PORT_T = 3'd4;

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_state_e;

  // (idx + 1) mod n for a port index.
  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] idx,
                                                  input int unsigned n);
    if (int'(idx) >= int'(n) - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Generic round-robin picker.
// Grants the first asserted request found scanning upward from i_ptr, wrapping at N.
// Ports:
//   i_req   [N]     request mask
//   i_ptr   [PTR_W] highest-priority index
//   o_grant [N]     one-hot grant (all zero when nothing requests)
//   o_valid         some request was granted
//   o_idx   [PTR_W] binary index of the granted request
module noc_rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid,
  output logic [PTR_W-1:0] o_idx
);

  int unsigned w_scan;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    w_scan  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_scan = (32'(i_ptr) + k) % N;
      if (!o_valid && i_req[w_scan]) begin
        o_grant[w_scan] = 1'b1;
        o_valid         = 1'b1;
        o_idx           = PTR_W'(w_scan);
      end
    end
  end

endmodule

// File: rtl/noc_out_port_allocator.sv
// Switch allocator for one router output port.
// Arbitrates among the input ports' VC buffer heads routed to this output, holds the
// output for a whole packet (head to tail), tracks downstream credits per VC and
// registers the crossbar select for the switch-traversal stage.
// Optional feature macro: NOC_LOCK_TIMEOUT_EN (breaks a lock after LOCK_TIMEOUT idle
// locked cycles and adds the o_lock_timeout pulse output).
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req      [NUM_IN] input i has a flit for this output
//   i_req_vc   [2*NUM_IN] downstream VC of input i at [2i+1:2i]
//   i_req_type [2*NUM_IN] flit type of input i (00 body, 01 head, 10 tail, 11 head+tail)
//   i_credit_in [NUM_VC] downstream freed one slot of VC v
//   o_grant    [NUM_IN] combinational one-hot pop
//   o_out_valid, o_out_sel, o_out_vc  registered crossbar control
//   o_credit_cnt [CW*NUM_VC] credit counters
//   o_locked, o_lock_owner  packet lock status
//   o_lock_timeout      (optional) one-cycle pulse when a lock is broken
//   o_err_credit_ovf    sticky credit overflow
module noc_out_port_allocator
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN   = 5,
  parameter int unsigned NUM_VC   = 4,
  parameter int unsigned VC_DEPTH = 8,
  parameter int unsigned CW       = 4
`ifdef NOC_LOCK_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT = 64
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_IN-1:0]      i_req,
  input  logic [VC_W*NUM_IN-1:0] i_req_vc,
  input  logic [2*NUM_IN-1:0]    i_req_type,
  input  logic [NUM_VC-1:0]      i_credit_in,
  output logic [NUM_IN-1:0]      o_grant,
  output logic                   o_out_valid,
  output logic [PORT_W-1:0]      o_out_sel,
  output logic [VC_W-1:0]        o_out_vc,
  output logic [CW*NUM_VC-1:0]   o_credit_cnt,
  output logic                   o_locked,
  output logic [PORT_W-1:0]      o_lock_owner,
`ifdef NOC_LOCK_TIMEOUT_EN
  output logic                   o_lock_timeout,
`endif
  output logic                   o_err_credit_ovf
);

  lock_state_e       r_state, w_state_nxt;
  logic [PORT_W-1:0] r_lock_owner, w_owner_nxt;
  logic [PORT_W-1:0] r_rr_ptr, w_ptr_nxt;
  logic              r_out_valid;
  logic [PORT_W-1:0] r_out_sel;
  logic [VC_W-1:0]   r_out_vc;
  logic              r_err_ovf;
  logic [CW-1:0]     r_credit [NUM_VC];

  logic [VC_W-1:0]   w_vc   [NUM_IN];
  logic [1:0]        w_type [NUM_IN];
  logic [NUM_IN-1:0] w_elig;
  logic [NUM_IN-1:0] w_arb_grant;
  logic              w_arb_valid;
  logic [PORT_W-1:0] w_win_idx;
  logic              w_grant_en;
  logic [VC_W-1:0]   w_win_vc;
  logic [1:0]        w_win_type;
  logic [NUM_VC-1:0] w_dec;

  // Eligibility uses the registered credit count, so a credit arriving in the same
  // cycle as a zero count cannot enable a grant until the following cycle.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_elig
    assign w_vc[gi]   = i_req_vc[VC_W*gi +: VC_W];
    assign w_type[gi] = i_req_type[2*gi +: 2];
    assign w_elig[gi] = i_req[gi] && (r_credit[w_vc[gi]] != '0) &&
                        ((r_state == StLocked) ? (r_lock_owner == PORT_W'(gi))
                                               : w_type[gi][0]);
  end

  noc_rr_arbiter #(
    .N     (NUM_IN),
    .PTR_W (PORT_W)
  ) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid),
    .o_idx   (w_win_idx)
  );

  assign w_grant_en = w_arb_valid && i_rst_n;
  assign o_grant    = i_rst_n ? w_arb_grant : '0;
  assign w_win_vc   = w_vc[w_win_idx];
  assign w_win_type = w_type[w_win_idx];

  for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_credit_out
    assign w_dec[gv] = w_grant_en && (w_win_vc == VC_W'(gv));
    assign o_credit_cnt[CW*gv +: CW] = r_credit[gv];
  end

`ifdef NOC_LOCK_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       r_lock_timeout;
  logic       w_timeout;

  // Fires on the cycle that would bring the idle count to LOCK_TIMEOUT.
  assign w_timeout = (r_state == StLocked) && !w_grant_en &&
                     (r_idle_cnt == 8'(LOCK_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt     <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_lock_timeout <= w_timeout;
      if ((r_state != StLocked) || w_grant_en || w_timeout) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 8'd1;
      end
    end
  end

  assign o_lock_timeout = r_lock_timeout;
`endif

  // Lock FSM next state; rr_ptr only advances when a packet starts.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_lock_owner;
    w_ptr_nxt   = r_rr_ptr;
    if (w_grant_en) begin
      unique case (w_win_type)
        FLIT_HEAD: begin
          w_state_nxt = StLocked;
          w_owner_nxt = w_win_idx;
          w_ptr_nxt   = next_port(w_win_idx, NUM_IN);
        end
        FLIT_HT: begin
          w_state_nxt = StUnlocked;
          w_ptr_nxt   = next_port(w_win_idx, NUM_IN);
        end
        FLIT_TAIL: begin
          w_state_nxt = StUnlocked;
        end
        default: begin
        end
      endcase
    end
`ifdef NOC_LOCK_TIMEOUT_EN
    else if (w_timeout) begin
      w_state_nxt = StUnlocked;
      w_ptr_nxt   = next_port(r_lock_owner, NUM_IN);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StUnlocked;
      r_lock_owner <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_owner <= w_owner_nxt;
      r_rr_ptr     <= w_ptr_nxt;
    end
  end

  // Switch-traversal pipeline register; select is held when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_out_vc    <= '0;
    end else begin
      r_out_valid <= w_grant_en;
      if (w_grant_en) begin
        r_out_sel <= w_win_idx;
        r_out_vc  <= w_win_vc;
      end
    end
  end

  // Credits: a grant and a returning credit on the same VC cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_credit[v] <= CW'(VC_DEPTH);
      end
      r_err_ovf <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_dec[v] && !i_credit_in[v]) begin
          r_credit[v] <= r_credit[v] - 1'b1;
        end else if (!w_dec[v] && i_credit_in[v]) begin
          if (r_credit[v] == CW'(VC_DEPTH)) begin
            r_err_ovf <= 1'b1;
          end else begin
            r_credit[v] <= r_credit[v] + 1'b1;
          end
        end
      end
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_sel        = r_out_sel;
  assign o_out_vc         = r_out_vc;
  assign o_locked         = (r_state == StLocked);
  assign o_lock_owner     = r_lock_owner;
  assign o_err_credit_ovf = r_err_ovf;

endmodule

// File: tb/tb_noc_out_port_allocator.sv
// Directed self-checking bench for noc_out_port_allocator.
// Inputs change on the falling clock edge; outputs are sampled 1 time unit later.
module tb_noc_out_port_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [9:0] req_vc;
  logic [9:0] req_type;
  logic [3:0] credit_in;
  logic [4:0] grant;
  logic       out_valid;
  logic [2:0] out_sel;
  logic [1:0] out_vc;
  logic [15:0] credit_cnt;
  logic       locked;
  logic [2:0] lock_owner;
  logic       err_ovf;
`ifdef NOC_LOCK_TIMEOUT_EN
  logic       lock_timeout;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  noc_out_port_allocator dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req            (req),
    .i_req_vc         (req_vc),
    .i_req_type       (req_type),
    .i_credit_in      (credit_in),
    .o_grant          (grant),
    .o_out_valid      (out_valid),
    .o_out_sel        (out_sel),
    .o_out_vc         (out_vc),
    .o_credit_cnt     (credit_cnt),
    .o_locked         (locked),
    .o_lock_owner     (lock_owner),
`ifdef NOC_LOCK_TIMEOUT_EN
    .o_lock_timeout   (lock_timeout),
`endif
    .o_err_credit_ovf (err_ovf)
  );

  task automatic idle_inputs();
    req = '0; req_vc = '0; req_type = '0; credit_in = '0;
  endtask

  // Leaves the bench on a falling edge with reset released.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 5'h1f; req_type = 10'h3ff; req_vc = '0; credit_in = '0;
    #12;
    n_checks++;
    if (grant !== 5'b0) $display("FAIL reset_grant: got %b want 00000", grant);
    else n_pass++;
    n_checks++;
    if (credit_cnt !== 16'h8888) $display("FAIL reset_credit: got %h want 8888", credit_cnt);
    else n_pass++;
    n_checks++;
    if ({out_valid, out_sel, out_vc, locked, lock_owner, err_ovf} !== 11'b0)
      $display("FAIL reset_state: got %b want 0", {out_valid, out_sel, out_vc, locked,
                                                    lock_owner, err_ovf});
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [4:0] exp;
    apply_reset();
    req = 5'h1f; req_type = 10'h3ff; req_vc = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = 5'b00001 << (k % 5);
      n_checks++;
      if (grant !== exp) $display("FAIL rot_grant%0d: got %b want %b", k, grant, exp);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (out_sel !== 3'((k - 1) % 5) || out_valid !== 1'b1)
          $display("FAIL rot_sel%0d: got %0d/%b want %0d/1", k, out_sel, out_valid, (k - 1) % 5);
        else n_pass++;
      end
      if (k == 5) begin
        n_checks++;
        if (credit_cnt[3:0] !== 4'd3) $display("FAIL rot_credit5: got %0d want 3", credit_cnt[3:0]);
        else n_pass++;
      end
      @(negedge clk);
    end
    req = '0;
    #1;
    n_checks++;
    if (credit_cnt[3:0] !== 4'd2 || out_sel !== 3'd0)
      $display("FAIL rot_end: got credit %0d sel %0d want 2/0", credit_cnt[3:0], out_sel);
    else n_pass++;
  endtask

  task automatic test_packet_lock();
    logic [4:0] t_req   [6] = '{5'b00010, 5'b00011, 5'b00001, 5'b00011, 5'b00001, 5'b00000};
    logic [9:0] t_type  [6] = '{10'h004, 10'h001, 10'h001, 10'h009, 10'h001, 10'h000};
    logic [4:0] t_grant [6] = '{5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00001, 5'b00000};
    logic       t_lock  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] t_own   [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [2:0] t_sel   [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    apply_reset();
    req_vc = 10'h004;
    for (int c = 0; c < 6; c++) begin
      req = t_req[c]; req_type = t_type[c];
      #1;
      n_checks++;
      if (grant !== t_grant[c]) $display("FAIL lock_grant%0d: got %b want %b", c, grant, t_grant[c]);
      else n_pass++;
      n_checks++;
      if (locked !== t_lock[c] || (t_lock[c] && lock_owner !== t_own[c]))
        $display("FAIL lock_state%0d: got %b/%0d want %b/%0d", c, locked, lock_owner,
                 t_lock[c], t_own[c]);
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (out_sel !== t_sel[c]) $display("FAIL lock_sel%0d: got %0d want %0d", c, out_sel, t_sel[c]);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (credit_cnt[7:4] !== 4'd5) $display("FAIL lock_credit: got %0d want 5", credit_cnt[7:4]);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_credit_drain();
    apply_reset();
    req = 5'b00100; req_vc = 10'h020; req_type = 10'h030;
    for (int c = 0; c < 12; c++) begin
      credit_in = (c == 9) ? 4'b0100 : 4'b0000;
      #1;
      n_checks++;
      if (grant !== ((c < 8 || c == 10) ? 5'b00100 : 5'b00000))
        $display("FAIL drain_grant%0d: got %b", c, grant);
      else n_pass++;
      if (c == 8 || c == 10 || c == 11) begin
        n_checks++;
        if (credit_cnt[11:8] !== ((c == 10) ? 4'd1 : 4'd0))
          $display("FAIL drain_credit%0d: got %0d want %0d", c, credit_cnt[11:8], (c == 10) ? 1 : 0);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_credit_collision();
    apply_reset();
    req = 5'b10000; req_vc = 10'h300; req_type = 10'h300;
    for (int c = 0; c < 11; c++) begin
      if (c == 4) req = '0;
      credit_in = (c >= 3 && c <= 7) ? 4'b1000 : 4'b0000;
      #1;
      if (c == 3) begin
        n_checks++;
        if (grant !== 5'b10000 || credit_cnt[15:12] !== 4'd5)
          $display("FAIL coll_pre: got %b/%0d want 10000/5", grant, credit_cnt[15:12]);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (credit_cnt[15:12] !== 4'd5) $display("FAIL coll_same: got %0d want 5", credit_cnt[15:12]);
        else n_pass++;
      end
      if (c == 7 || c == 8 || c == 10) begin
        n_checks++;
        if (credit_cnt[15:12] !== 4'd8 || err_ovf !== (c != 7))
          $display("FAIL coll_ovf%0d: got %0d/%b want 8/%b", c, credit_cnt[15:12], err_ovf, c != 7);
        else n_pass++;
      end
      @(negedge clk);
    end
    apply_reset();
    #1;
    n_checks++;
    if (err_ovf !== 1'b0) $display("FAIL coll_clear: got %b want 0", err_ovf);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    req = 5'b00010; req_vc = '0;
    for (int c = 0; c < 4; c++) begin
      req_type = (c == 0) ? 10'h004 : 10'h000;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (locked !== 1'b1 || lock_owner !== 3'd1 || credit_cnt[3:0] !== 4'd4 || grant !== 5'b00010)
      $display("FAIL mid_pre: got %b/%0d/%0d/%b want 1/1/4/00010", locked, lock_owner,
               credit_cnt[3:0], grant);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (locked !== 1'b0 || grant !== 5'b0 || out_valid !== 1'b0 || credit_cnt !== 16'h8888)
      $display("FAIL mid_reset: got %b/%b/%b/%h want 0/00000/0/8888", locked, grant, out_valid,
               credit_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    req = 5'b10000; req_type = 10'h100; req_vc = '0;
    #1;
    n_checks++;
    if (grant !== 5'b10000) $display("FAIL mid_t_grant: got %b want 10000", grant);
    else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    n_checks++;
    if (locked !== 1'b1 || lock_owner !== 3'd4 || out_sel !== 3'd4)
      $display("FAIL mid_t_lock: got %b/%0d/%0d want 1/4/4", locked, lock_owner, out_sel);
    else n_pass++;
  endtask

`ifdef NOC_LOCK_TIMEOUT_EN
  task automatic test_lock_timeout();
    int bad = 0;
    apply_reset();
    req = 5'b00100; req_type = 10'h010; req_vc = '0;
    #1;
    n_checks++;
    if (grant !== 5'b00100) $display("FAIL to_head: got %b want 00100", grant);
    else n_pass++;
    @(negedge clk);
    req = 5'b01000; req_type = 10'h040;
    for (int k = 1; k <= 64; k++) begin
      #1;
      if (grant !== 5'b0 || lock_timeout !== 1'b0 || locked !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) $display("FAIL to_idle: got %0d bad cycles want 0", bad);
    else n_pass++;
    #1;
    n_checks++;
    if (lock_timeout !== 1'b1 || locked !== 1'b0 || grant !== 5'b01000)
      $display("FAIL to_fire: got %b/%b/%b want 1/0/01000", lock_timeout, locked, grant);
    else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    n_checks++;
    if (lock_timeout !== 1'b0 || locked !== 1'b1 || lock_owner !== 3'd3)
      $display("FAIL to_after: got %b/%b/%0d want 0/1/3", lock_timeout, locked, lock_owner);
    else n_pass++;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_rotation();
    test_packet_lock();
    test_credit_drain();
    test_credit_collision();
    test_reset_mid_packet();
`ifdef NOC_LOCK_TIMEOUT_EN
    test_lock_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
